// File: rtl/string4_eval_if.sv
// Character-stream bus for string4_eval: one ASCII byte in per clock,
// registered legality flag and running value out.
interface string4_eval_if;
  logic [7:0] in;
  logic       out;
  logic [7:0] res;

  modport master (output in, input out, input res);
  modport slave  (input in, output out, output res);
endinterface

// File: rtl/string4_eval.sv
// Serial recognizer/evaluator for expressions of single digits joined by '+'
// and '*', with '*' binding tighter; all arithmetic wraps modulo 256.
module string4_eval (
  input  logic           clk,
  input  logic           clr,
  string4_eval_if.slave  bus
);

  typedef enum logic [2:0] {INIT, NUM, OPA, OPM, ERR} state_t;

  // Declaration initializers give the same power-up values as a clr.
  state_t     state = INIT;
  logic [7:0] sum   = 8'd0;
  logic [7:0] prod  = 8'd0;
  logic       out_q = 1'b0;
  logic [7:0] res_q = 8'd0;

  state_t     state_n;
  logic [7:0] sum_n;
  logic [7:0] prod_n;
  logic       out_n;
  logic [7:0] res_n;

  logic       is_dig;
  logic       is_add;
  logic       is_mul;
  logic [7:0] digit;

  assign is_dig = (bus.in >= 8'h30) && (bus.in <= 8'h39);
  assign is_add = (bus.in == 8'h2B);
  assign is_mul = (bus.in == 8'h2A);
  assign digit  = bus.in - 8'h30;

  // sum holds the completed '+' terms, prod the term still being multiplied.
  always_comb begin
    state_n = state;
    sum_n   = sum;
    prod_n  = prod;

    unique case (state)
      INIT, OPA: begin
        if (is_dig) begin
          state_n = NUM;
          prod_n  = digit;
        end else begin
          state_n = ERR;
        end
      end
      OPM: begin
        if (is_dig) begin
          state_n = NUM;
          prod_n  = prod * digit;
        end else begin
          state_n = ERR;
        end
      end
      NUM: begin
        if (is_add) begin
          state_n = OPA;
          sum_n   = sum + prod;
          prod_n  = 8'd0;
        end else if (is_mul) begin
          state_n = OPM;
        end else begin
          state_n = ERR;
        end
      end
      ERR: state_n = ERR;
      default: state_n = ERR;
    endcase

    out_n = (state_n == NUM);
    if ((state_n == ERR) || (state_n == INIT))
      res_n = 8'd0;
    else
      res_n = sum_n + prod_n;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= INIT;
      sum   <= 8'd0;
      prod  <= 8'd0;
      out_q <= 1'b0;
      res_q <= 8'd0;
    end else begin
      state <= state_n;
      sum   <= sum_n;
      prod  <= prod_n;
      out_q <= out_n;
      res_q <= res_n;
    end
  end

  assign bus.out = out_q;
  assign bus.res = res_q;

endmodule

// File: tb/tb_string4_eval.sv
// Self-checking bench for string4_eval: directed vector table, a few
// hand-written sequences, then random streams against a string-level model.
module tb_string4_eval;

  logic clk = 1'b0;
  logic clr;

  string4_eval_if bus ();

  string4_eval dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       c;
    logic [7:0] ch;
    logic       eo;
    logic [7:0] er;
  } vec_t;

  vec_t            vecs[$];
  logic [7:0]      hist[$];
  int              checks   = 0;
  int              failures = 0;

  // Reference: judges the whole string seen since the last clr, splitting it
  // into '+'-separated products of digits rather than tracking any state.
  function automatic logic [8:0] model();
    int n;
    int last;
    int sum;
    int term;
    n = hist.size();
    if (n == 0) return 9'd0;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) begin
        if (hist[i] < 8'h30 || hist[i] > 8'h39) return 9'd0;
      end else begin
        if (hist[i] != 8'h2B && hist[i] != 8'h2A) return 9'd0;
      end
    end
    last = (n % 2 == 1) ? n - 1 : n - 2;
    sum  = 0;
    term = int'(hist[0]) - 48;
    for (int i = 1; i <= last; i += 2) begin
      if (hist[i] == 8'h2A)
        term = (term * (int'(hist[i+1]) - 48)) % 256;
      else begin
        sum  = (sum + term) % 256;
        term = int'(hist[i+1]) - 48;
      end
    end
    sum = (sum + term) % 256;
    return {(n % 2 == 1) ? 1'b1 : 1'b0, sum[7:0]};
  endfunction

  task automatic applyStimulus(input logic c, input logic [7:0] ch);
    clr    = c;
    bus.in = ch;
    @(posedge clk);
    #1;
    if (c) hist.delete();
    else   hist.push_back(ch);
  endtask

  task automatic checkOutput(input string name, input logic eo, input logic [7:0] er);
    checks++;
    if (bus.out !== eo || bus.res !== er) begin
      failures++;
      $display("[TB] FAIL %s: got out=%0b res=%0d, expected out=%0b res=%0d",
               name, bus.out, bus.res, eo, er);
    end
  endtask

  task automatic addVec(input logic c, input byte ch, input logic eo, input int er);
    vec_t v;
    v.c  = c;
    v.ch = ch;
    v.eo = eo;
    v.er = er[7:0];
    vecs.push_back(v);
  endtask

  logic [8:0] exp;
  int         r;
  logic [7:0] ch;

  initial begin
    clr    = 1'b0;
    bus.in = 8'h31;
    #1;
    checkOutput("powerup", 1'b0, 8'd0);

    // Power-up stream with no clr, then the directed cases.
    addVec(0, "1", 1, 1);   addVec(0, "+", 0, 1);   addVec(0, "2", 1, 3);
    addVec(1, "0", 0, 0);
    addVec(0, "2", 1, 2);   addVec(0, "+", 0, 2);   addVec(0, "3", 1, 5);
    addVec(0, "*", 0, 5);   addVec(0, "4", 1, 14);
    addVec(1, "0", 0, 0);
    addVec(0, "9", 1, 9);   addVec(0, "*", 0, 9);   addVec(0, "9", 1, 81);
    addVec(0, "*", 0, 81);  addVec(0, "9", 1, 217); addVec(0, "+", 0, 217);
    addVec(0, "9", 1, 226);
    addVec(1, "0", 0, 0);
    addVec(0, "1", 1, 1);   addVec(0, "2", 0, 0);   addVec(0, "+", 0, 0);
    addVec(0, "3", 0, 0);   addVec(1, "0", 0, 0);   addVec(0, "5", 1, 5);
    addVec(1, "0", 0, 0);   addVec(0, "+", 0, 0);   addVec(0, "5", 0, 0);
    addVec(1, "0", 0, 0);   addVec(0, "a", 0, 0);
    addVec(1, "0", 0, 0);   addVec(0, "*", 0, 0);
    addVec(1, "0", 0, 0);   addVec(0, "1", 1, 1);   addVec(0, "+", 0, 1);
    addVec(0, "+", 0, 0);
    addVec(1, "0", 0, 0);   addVec(0, "3", 1, 3);   addVec(0, "+", 0, 3);
    addVec(1, "7", 0, 0);   addVec(0, "4", 1, 4);
    addVec(1, "0", 0, 0);   addVec(0, "/", 0, 0);
    addVec(1, "0", 0, 0);   addVec(0, ":", 0, 0);
    addVec(1, "0", 0, 0);   addVec(0, "0", 1, 0);   addVec(0, "*", 0, 0);
    addVec(0, "9", 1, 0);   addVec(0, "+", 0, 0);   addVec(0, "9", 1, 9);
    addVec(0, ",", 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].c, vecs[i].ch);
      checkOutput($sformatf("vec%0d", i), vecs[i].eo, vecs[i].er);
    end

    // clr held several cycles with digits present: none may be consumed.
    applyStimulus(1'b1, "8");
    applyStimulus(1'b1, "8");
    applyStimulus(1'b1, "8");
    checkOutput("clr_hold", 1'b0, 8'd0);
    applyStimulus(1'b0, "6");
    checkOutput("after_hold", 1'b1, 8'd6);

    // ERR stays sticky across a long legal-looking tail.
    applyStimulus(1'b0, "7");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, (i % 2 == 0) ? 8'h2B : 8'h32);
    checkOutput("err_sticky", 1'b0, 8'd0);

    // Random streams versus the string-level model.
    applyStimulus(1'b1, 8'h00);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        applyStimulus(1'b1, 8'($urandom));
      end else begin
        if (r < 55)      ch = 8'h30 + 8'($urandom_range(0, 9));
        else if (r < 73) ch = 8'h2B;
        else if (r < 91) ch = 8'h2A;
        else             ch = 8'($urandom);
        applyStimulus(1'b0, ch);
      end
      exp = model();
      checkOutput($sformatf("rand%0d", i), exp[8], exp[7:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
